// File: rtl/imager_tx.sv
// imager_tx: emits an 8-byte W/H header followed by W*H*3 pixel bytes as an imager byte stream.
// Optional inter-line blanking is compiled in with IMAGER_TX_GAP_EN (LINE_GAP blank cycles per line break).
module imager_tx #(
  parameter int unsigned LINE_GAP = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] line_width,
  input  logic [31:0] pic_height,
  input  logic [7:0]  d_in,
  input  logic        d_valid,
  output logic        d_ready,
  output logic        pxq,
  output logic [7:0]  dout,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  // Handshake: a pixel byte transfers on a rising edge where d_valid and d_ready are both 1;
  // d_ready depends only on state, never on d_valid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PIX  = 2'd2
`ifdef IMAGER_TX_GAP_EN
    ,
    S_GAP  = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] w_q, w_d;
  logic [31:0] h_q, h_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] col_cnt_q, col_cnt_d;
  logic [31:0] row_cnt_q, row_cnt_d;
  logic        pxq_q, pxq_d;
  logic [7:0]  dout_q, dout_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
`ifdef IMAGER_TX_GAP_EN
  logic [31:0] gap_cnt_q, gap_cnt_d;
`else
  logic        unused_line_gap;
  assign unused_line_gap = ^LINE_GAP;
`endif

  logic [2:0]  hdr_next;
  logic [63:0] hdr_shift;
  logic        last_col;
  logic        last_row;

  // hdr_idx_q is the header byte already on dout; byte 0 goes out straight from IDLE.
  assign hdr_next  = hdr_idx_q + 3'd1;
  assign hdr_shift = {w_q, h_q} << {hdr_next, 3'b000};
  assign last_col  = (col_cnt_q == w_q - 32'd1);
  assign last_row  = (row_cnt_q == h_q - 32'd1);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      hdr_idx_q    <= '0;
      byte_cnt_q   <= '0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      pxq_q        <= 1'b0;
      dout_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef IMAGER_TX_GAP_EN
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      hdr_idx_q    <= hdr_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      pxq_q        <= pxq_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef IMAGER_TX_GAP_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    hdr_idx_d    = hdr_idx_q;
    byte_cnt_d   = byte_cnt_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    pxq_d        = 1'b0;
    dout_d       = dout_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
`ifdef IMAGER_TX_GAP_EN
    gap_cnt_d    = gap_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d       = line_width;
          h_d       = pic_height;
          hdr_idx_d = 3'd0;
          busy_d    = 1'b1;
          pxq_d     = 1'b1;
          dout_d    = line_width[31:24];
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        pxq_d     = 1'b1;
        dout_d    = hdr_shift[63:56];
        hdr_idx_d = hdr_next;
        if (hdr_idx_q == 3'd6) begin
          hdr_idx_d  = 3'd0;
          byte_cnt_d = '0;
          col_cnt_d  = '0;
          row_cnt_d  = '0;
          if (w_q == 32'd0 || h_q == 32'd0) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            state_d = S_PIX;
          end
        end
      end
      S_PIX: begin
        if (d_valid) begin
          pxq_d  = 1'b1;
          dout_d = d_in;
          if (byte_cnt_q == 2'd2) begin
            byte_cnt_d = 2'd0;
            if (last_col) begin
              col_cnt_d = '0;
              if (last_row) begin
                row_cnt_d    = '0;
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                frame_done_d = 1'b1;
              end else begin
                row_cnt_d = row_cnt_q + 32'd1;
`ifdef IMAGER_TX_GAP_EN
                if (LINE_GAP != 0) begin
                  gap_cnt_d = '0;
                  state_d   = S_GAP;
                end
`endif
              end
            end else begin
              col_cnt_d = col_cnt_q + 32'd1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
`ifdef IMAGER_TX_GAP_EN
      S_GAP: begin
        if (gap_cnt_q == LINE_GAP - 32'd1) begin
          gap_cnt_d = '0;
          state_d   = S_PIX;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign d_ready    = (state_q == S_PIX);
  assign pxq        = pxq_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imager_tx.sv
// Bench for imager_tx: stream monitor scores every pxq byte against a queue of {frame_done, byte}.
module tb_imager_tx;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] line_width = '0;
  logic [31:0] pic_height = '0;
  logic [7:0]  d_in = '0;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic        pxq;
  logic [7:0]  dout;
  logic        busy;
  logic        frame_done;
  logic [1:0]  dbg_state;

  imager_tx #(.LINE_GAP(4)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .start      (start),
    .line_width (line_width),
    .pic_height (pic_height),
    .d_in       (d_in),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .pxq        (pxq),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  always #5 clk_in = ~clk_in;

  logic [8:0] exp_q[$];
  int         run_q[$];
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int pxq_cnt = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int hdr0_cyc = 0;
  int fd_next_delta = -1;
  int zrun = 0;
  bit fd_pending = 0;
  bit arm = 0;
  bit dready_seen = 0;
  logic [8:0] exp_e;

  // Stream monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (rst) begin
      if (d_ready) dready_seen = 1;
      if (pxq) begin
        pxq_cnt = pxq_cnt + 1;
        if (arm) begin
          hdr0_cyc = cyc;
          arm = 0;
        end
        if (fd_pending) begin
          fd_next_delta = cyc - fd_cyc;
          fd_pending = 0;
        end
        if (zrun > 0) run_q.push_back(zrun);
        zrun = 0;
        vectors = vectors + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL stream: unexpected byte %h fd=%b at cycle %0d", dout, frame_done, cyc);
        end else begin
          exp_e = exp_q.pop_front();
          if ({frame_done, dout} !== exp_e)
            begin
              errors = errors + 1;
              $display("FAIL stream: got fd=%b byte=%h, want fd=%b byte=%h at cycle %0d",
                       frame_done, dout, exp_e[8], exp_e[7:0], cyc);
            end
        end
      end else begin
        if (busy) zrun = zrun + 1;
        if (frame_done) begin
          vectors = vectors + 1;
          errors = errors + 1;
          $display("FAIL frame_done_qual: frame_done=1 with pxq=0 at cycle %0d", cyc);
        end
      end
      if (frame_done) begin
        fd_cnt = fd_cnt + 1;
        fd_cyc = cyc;
        fd_pending = 1;
      end
    end
  end

  function automatic void push_hdr(input logic [31:0] w, input logic [31:0] h,
                                   input bit fd, input int nbytes);
    logic [63:0] hw;
    hw = {w, h};
    for (int k = 0; k < nbytes; k++)
      exp_q.push_back({fd && (k == 7), hw[63-8*k -: 8]});
  endfunction

  function automatic void push_pix(input int n, input logic [7:0] base);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      exp_q.push_back({(i == n - 1), b});
    end
  endfunction

  task automatic clear_stats();
    pxq_cnt = 0;
    fd_cnt = 0;
    dready_seen = 0;
    run_q.delete();
    fd_next_delta = -1;
    fd_pending = 0;
    zrun = 0;
    arm = 1;
  endtask

  task automatic start_frame(input logic [31:0] w, input logic [31:0] h);
    line_width = w;
    pic_height = h;
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
  endtask

  // Offers bytes base..base+n-1; pat[k] gates d_valid on the k-th cycle that d_ready is high.
  task automatic feed(input int n, input logic [7:0] base, input int pat_len, input logic [15:0] pat);
    int i = 0;
    int k = 0;
    int guard = 0;
    logic acc;
    while (i < n && guard < 500) begin
      d_in = base + 8'(i);
      if (d_ready) begin
        d_valid = (k < pat_len) ? pat[k] : 1'b1;
        k++;
      end else begin
        d_valid = 1'b1;
      end
      @(negedge clk_in);
      acc = d_valid && d_ready;
      @(posedge clk_in); #1;
      if (acc) i++;
      guard++;
    end
    d_valid = 1'b0;
    if (i < n) begin
      vectors = vectors + 1;
      errors = errors + 1;
      $display("FAIL feed_timeout: accepted %0d of %0d bytes", i, n);
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk_in);
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s_drain: %0d expected bytes never appeared, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors = vectors + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    vectors = vectors + 1;
    if ({pxq, dout, busy, frame_done, d_ready, dbg_state} !== 14'd0) begin
      errors = errors + 1;
      $display("FAIL reset_values: got pxq=%b dout=%h busy=%b fd=%b rdy=%b st=%0d, want all 0",
               pxq, dout, busy, frame_done, d_ready, dbg_state);
    end
    @(posedge clk_in); #1;
    rst = 1'b1;
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset_mid_header();
    clear_stats();
    push_hdr(32'd2, 32'd1, 0, 3);
    start_frame(32'd2, 32'd1);
    repeat (3) @(posedge clk_in);
    #1;
    rst = 1'b0;
    #1;
    vectors = vectors + 1;
    if (pxq !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL midhdr_abort: got pxq=%b busy=%b fd=%b, want 0 0 0", pxq, busy, frame_done);
    end
    check_int("midhdr_bytes_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check_int("midhdr_no_fd", fd_cnt, 0);
    clear_stats();
    push_hdr(32'd2, 32'd1, 0, 8);
    push_pix(6, 8'h40);
    start_frame(32'd2, 32'd1);
    feed(6, 8'h40, 0, 16'h0);
    drain("restart");
    check_int("restart_pxq_cnt", pxq_cnt, 14);
    check_int("restart_fd_cnt", fd_cnt, 1);
  endtask

  task automatic test_basic();
    clear_stats();
    push_hdr(32'd2, 32'd2, 0, 8);
    push_pix(12, 8'h01);
    start_frame(32'd2, 32'd2);
    feed(12, 8'h01, 0, 16'h0);
    drain("basic");
    check_int("basic_pxq_cnt", pxq_cnt, 20);
    check_int("basic_fd_cnt", fd_cnt, 1);
    check_int("basic_span", fd_cyc - hdr0_cyc + 1, 20);
    check_int("basic_busy_after", int'(busy), 0);
  endtask

  task automatic test_bubbles();
    clear_stats();
    push_hdr(32'd1, 32'd1, 0, 8);
    push_pix(3, 8'hA0);
    start_frame(32'd1, 32'd1);
    feed(3, 8'hA0, 6, 16'b101001);
    drain("bubble");
    check_int("bubble_pxq_cnt", pxq_cnt, 11);
    check_int("bubble_span", fd_cyc - hdr0_cyc + 1, 14);
    check_int("bubble_fd_cnt", fd_cnt, 1);
  endtask

  task automatic test_zero_dim();
    clear_stats();
    push_hdr(32'd0, 32'd5, 1, 8);
    start_frame(32'd0, 32'd5);
    drain("zero");
    check_int("zero_pxq_cnt", pxq_cnt, 8);
    check_int("zero_fd_cnt", fd_cnt, 1);
    check_int("zero_dready_seen", int'(dready_seen), 0);
    check_int("zero_busy_after", int'(busy), 0);
  endtask

  task automatic test_start_while_busy();
    clear_stats();
    push_hdr(32'd1, 32'd1, 0, 8);
    push_pix(3, 8'h80);
    push_hdr(32'd0, 32'd0, 1, 8);
    start_frame(32'd1, 32'd1);
    fork
      feed(3, 8'h80, 0, 16'h0);
      begin
        for (int g = 0; g < 50 && !d_ready; g++) begin
          @(posedge clk_in); #1;
        end
        start = 1'b1;
        line_width = 32'd9;
        pic_height = 32'd1;
        @(posedge clk_in); #1;
        start = 1'b0;
        @(posedge clk_in); #1;
        start = 1'b1;
        line_width = 32'd0;
        pic_height = 32'd0;
        repeat (2) @(posedge clk_in);
        #1;
        start = 1'b0;
      end
    join
    drain("busystart");
    check_int("busystart_fd_cnt", fd_cnt, 2);
    check_int("busystart_next_hdr_delay", fd_next_delta, 1);
    check_int("busystart_pxq_cnt", pxq_cnt, 19);
  endtask

`ifdef IMAGER_TX_GAP_EN
  task automatic test_line_gap();
    clear_stats();
    push_hdr(32'd1, 32'd3, 0, 8);
    push_pix(9, 8'h10);
    start_frame(32'd1, 32'd3);
    feed(9, 8'h10, 0, 16'h0);
    drain("gap");
    check_int("gap_run_count", run_q.size(), 2);
    check_int("gap_run0", (run_q.size() > 0) ? run_q[0] : -1, 4);
    check_int("gap_run1", (run_q.size() > 1) ? run_q[1] : -1, 4);
    check_int("gap_span", fd_cyc - hdr0_cyc + 1, 25);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_header();
    test_basic();
    test_bubbles();
    test_zero_dim();
    test_start_while_busy();
`ifdef IMAGER_TX_GAP_EN
    test_line_gap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
